// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 single-bit mux among 16 requesters.
// Registered one-hot grant and mux select, with a bounded hold time per owner.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HCNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic        sel3,
    output logic        sel2,
    output logic        sel1,
    output logic        sel0,
    output logic        rearb
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(MAX_HOLD);
    // With no limit the counter simply saturates at all-ones
    localparam logic [HCNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HCNT_W{1'b1}} : HOLD_LIM;

    state_t            state_reg, state_next;
    logic [15:0]       gnt_reg, gnt_next;
    logic [3:0]        sel_reg, sel_next;
    logic [3:0]        ptr_reg, ptr_next;
    logic [HCNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              rearb_reg, rearb_next;

    logic [15:0]       owner_oh;
    logic [4:0]        pick_idle;
    logic [4:0]        pick_rot;
    logic              own_req;
    logic              others;
    logic              limit_hit;
    logic              do_grant;
    logic [3:0]        win;

    // Returns {found, index} of the first set bit of r scanning start, start+1, ... mod 16
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
        logic [3:0] idx;
        rr_pick = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_owner
            assign owner_oh[gi] = (sel_reg == 4'(gi));
        end
    endgenerate

    assign own_req   = req[sel_reg];
    assign others    = |(req & ~owner_oh);
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIM);
    assign pick_idle = rr_pick(req, ptr_reg);
    // Rotation never re-selects the current owner
    assign pick_rot  = rr_pick(req & ~owner_oh, sel_reg + 4'd1);

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        sel_next      = sel_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        rearb_next    = 1'b0;
        do_grant      = 1'b0;
        win           = pick_rot[3:0];

        case (state_reg)
            IDLE: begin
                if (pick_idle[4]) begin
                    do_grant = 1'b1;
                    win      = pick_idle[3:0];
                end else begin
                    gnt_next = '0;
                end
            end
            GRANT: begin
                if (others && (!own_req || limit_hit)) begin
                    do_grant = 1'b1;
                end else if (!own_req) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt_reg + HCNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_grant) begin
            state_next    = GRANT;
            gnt_next      = 16'd1 << win;
            sel_next      = win;
            ptr_next      = win + 4'd1;
            hold_cnt_next = HCNT_W'(1);
            rearb_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            rearb_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            rearb_reg    <= rearb_next;
        end
    end

    assign gnt                      = gnt_reg;
    assign gnt_valid                = |gnt_reg;
    assign {sel3, sel2, sel1, sel0} = sel_reg;
    assign rearb                    = rearb_reg;
endmodule
